inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch unit for the single-issue NPC core. Owns the PC register and issues one word request at a time to instruction memory. Presents each fetched `{pc, inst}` pair to the decode stage over a valid/ready handshake. Accepts jump/branch redirects from downstream and discards any stale in-flight fetch.

## Interface
Parameters:
- `RESET_PC`, `32'h8000_0000`: PC loaded on reset.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid_o`  out  1  fetch request valid.
- `imem_req_ready_i`  in  1  memory accepts request.
- `imem_req_addr_o`  out  32  fetch address (word-aligned).
- `imem_rsp_valid_i`  in  1  response data valid. Always accepted; no backpressure.
- `imem_rsp_data_i`  in  32  fetched instruction word.
- `id_valid_o`  out  1  instruction available to decode.
- `id_ready_i`  in  1  decode consumes instruction.
- `id_pc_o`  out  32  PC of presented instruction.
- `id_inst_o`  out  32  presented instruction.
- `redirect_valid_i`  in  1  take jump/branch.
- `redirect_target_i`  in  32  new PC. Bits [1:0] are forced to 0.
- `halt_i`  in  1  stop issuing new fetches (ebreak/program done).

## Operation
State registers:
- `pc` (32 bits).
- `inst_q` (32 bits).
- `drop_q` (1 bit): discard next response.
- FSM with states S_REQ, S_WAIT, S_OUT.

While `rst`=1:
- All outputs are 0.
- Next state is S_REQ, `pc`=RESET_PC, `drop_q`=0, `inst_q`=0.

Output decode:
- `imem_req_valid_o` = (state==S_REQ) & ~halt_i & ~redirect_valid_i & ~rst.
- `imem_req_addr_o` = `pc`.
- `id_valid_o` = (state==S_OUT) & ~redirect_valid_i & ~rst. Redirect kills the presented instruction combinationally.
- `id_pc_o` = `pc`, `id_inst_o` = `inst_q`.

S_REQ transitions:
- Redirect: `pc` ← target. Stay in S_REQ.
- Else request handshake (valid & ready): go to S_WAIT, `drop_q`=0.
- Else stay in S_REQ. This includes halt.

S_WAIT transitions:
- Redirect (with or without a same-cycle response): `pc` ← target. If the response arrives that cycle, discard it and go to S_REQ. Otherwise set `drop_q`=1 and stay in S_WAIT.
- Response with `drop_q`=1: discard, clear `drop_q`, go to S_REQ.
- Response with `drop_q`=0: `inst_q` ← data, go to S_OUT.

S_OUT transitions:
- Redirect has priority over handshake: `pc` ← target, go to S_REQ. The instruction is never consumed.
- Else decode handshake: `pc` ← `pc`+4 (mod 2^32, wraps), go to S_REQ.
- Else hold `pc` and `inst_q` stable.

Ignored inputs:
- `imem_rsp_valid_i` in S_REQ or S_OUT (spurious response).
- `halt_i` outside S_REQ. An in-flight fetch completes and is presented normally.

## Timing
- At most one outstanding request.
- Response arrives no earlier than the cycle after request acceptance.
- Minimum latency from request acceptance to `id_valid_o`: 2 cycles.
  - Cycle N: request handshake.
  - Cycle N+1: response, registered.
  - Cycle N+2: `id_valid_o`=1.
- Peak throughput: 1 instruction per 3 cycles (S_REQ → S_WAIT → S_OUT).
- First request after reset deassert: `imem_req_valid_o`=1, addr=RESET_PC in the first cycle with `rst`=0.
- Redirect lands in `pc` on the next edge. The request to the target issues the following cycle.
- `id_pc_o`/`id_inst_o` are stable while `id_valid_o`=1 and `id_ready_i`=0.
- Reset mid-fetch abandons the request. The bench memory must also be reset; no response is expected afterwards.

## Structure
- Shared constants go in `defines.v`:
  - `INST_ADDR_BUS`, `INST_DATA_BUS`.
  - `RESET_PC` default.
  - FSM state encoding `IFU_S_REQ`/`IFU_S_WAIT`/`IFU_S_OUT` (2-bit).
- Single flat module; no sub-module.
- The `pc` next-value mux (reset / redirect / +4 / hold) is one always block, separate from the FSM block.

## Test plan
- **Reset fetch:** release reset; memory ready=1, 1-cycle response 0x00000413 → request addr 0x80000000 first cycle; `id_valid_o`=1 two cycles after acceptance with `id_pc_o`=0x80000000, `id_inst_o`=0x00000413.
- **Sequential stream:** memory returns PC-indexed words; `id_ready_i`=1 → PCs 0x80000000, 0x80000004, 0x80000008, one instruction every 3 cycles.
- **Decode backpressure:** `id_ready_i`=0 for 5 cycles in S_OUT → outputs stable, no new request. Then ready=1 → next request at 0x80000004.
- **Redirect in S_WAIT:** target 0x80000100 while waiting, response arrives 3 cycles later → that word is never presented; next request at 0x80000100.
- **Redirect in S_OUT with `id_ready_i`=1 same cycle:** `id_valid_o`=0 that cycle, `pc`=0x80000100, no +4.
- **Halt and wrap:**
  - `halt_i`=1 in S_REQ → `imem_req_valid_o`=0 until deassert.
  - Redirect to 0xFFFFFFFC, consume → next fetch at 0x00000000.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Holds bus widths, the default reset PC and the fetch FSM state encoding.
package inst_fetch_unit_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_DATA_BUS = 32;

    localparam logic [INST_ADDR_BUS-1:0] RESET_PC_DEF = 32'h8000_0000;

    typedef enum logic [1:0] {
        IFU_S_REQ  = 2'd0,
        IFU_S_WAIT = 2'd1,
        IFU_S_OUT  = 2'd2
    } ifu_state_e;

    // Fetch addresses are always word aligned; low two bits of any target are dropped.
    function automatic logic [INST_ADDR_BUS-1:0] align_word(input logic [INST_ADDR_BUS-1:0] a);
        return {a[INST_ADDR_BUS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// Single-outstanding instruction fetch: owns the PC, issues one word request at a
// time, presents {pc, inst} to decode, and squashes stale fetches on redirect.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [INST_ADDR_BUS-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_valid_o,
    input  logic                     imem_req_ready_i,
    output logic [INST_ADDR_BUS-1:0] imem_req_addr_o,
    input  logic                     imem_rsp_valid_i,
    input  logic [INST_DATA_BUS-1:0] imem_rsp_data_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [INST_ADDR_BUS-1:0] id_pc_o,
    output logic [INST_DATA_BUS-1:0] id_inst_o,
    input  logic                     redirect_valid_i,
    input  logic [INST_ADDR_BUS-1:0] redirect_target_i,
    input  logic                     halt_i
);

    ifu_state_e               state;
    logic [INST_ADDR_BUS-1:0] pc;
    logic [INST_ADDR_BUS-1:0] pc_d;
    logic [INST_DATA_BUS-1:0] inst_q;
    logic                     drop_q;
    logic                     req_fire;
    logic                     id_fire;

    // A redirect kills both the outgoing request and the presented instruction in the same cycle.
    assign imem_req_valid_o = (state == IFU_S_REQ) & ~halt_i & ~redirect_valid_i & ~rst;
    assign id_valid_o       = (state == IFU_S_OUT) & ~redirect_valid_i & ~rst;
    assign imem_req_addr_o  = rst ? '0 : pc;
    assign id_pc_o          = rst ? '0 : pc;
    assign id_inst_o        = rst ? '0 : inst_q;

    assign req_fire = imem_req_valid_o & imem_req_ready_i;
    assign id_fire  = id_valid_o & id_ready_i;

    always_comb begin
        pc_d = pc;
        if (rst)
            pc_d = RESET_PC;
        else if (redirect_valid_i)
            pc_d = align_word(redirect_target_i);
        else if (id_fire)
            pc_d = pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        pc <= pc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IFU_S_REQ;
            drop_q <= 1'b0;
            inst_q <= '0;
        end else begin
            case (state)
                IFU_S_REQ: begin
                    if (req_fire) begin
                        state  <= IFU_S_WAIT;
                        drop_q <= 1'b0;
                    end
                end
                IFU_S_WAIT: begin
                    // The in-flight word belongs to the old path; remember to discard it if it is still coming.
                    if (redirect_valid_i) begin
                        if (imem_rsp_valid_i)
                            state <= IFU_S_REQ;
                        else
                            drop_q <= 1'b1;
                    end else if (imem_rsp_valid_i) begin
                        if (drop_q) begin
                            drop_q <= 1'b0;
                            state  <= IFU_S_REQ;
                        end else begin
                            inst_q <= imem_rsp_data_i;
                            state  <= IFU_S_OUT;
                        end
                    end
                end
                IFU_S_OUT: begin
                    if (redirect_valid_i || id_fire)
                        state <= IFU_S_REQ;
                end
                default: state <= IFU_S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: a directed vector table for the corner cases, then
// randomized traffic checked against a transaction-level fetch model.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic        halt_i;

    int vectors = 0;
    int miscompares = 0;

    inst_fetch_unit #(.RESET_PC(32'h8000_0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_rsp_valid_i  (imem_rsp_valid_i),
        .imem_rsp_data_i   (imem_rsp_data_i),
        .id_valid_o        (id_valid_o),
        .id_ready_i        (id_ready_i),
        .id_pc_o           (id_pc_o),
        .id_inst_o         (id_inst_o),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .halt_i            (halt_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rq_rdy;
        logic        rs_vld;
        logic [31:0] rs_data;
        logic        id_rdy;
        logic        rd_vld;
        logic [31:0] rd_tgt;
        logic        hlt;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic r, input logic rqr, input logic rsv, input logic [31:0] rsd,
                       input logic idr, input logic rdv, input logic [31:0] tgt, input logic h,
                       input logic erv, input logic [31:0] eaddr, input logic eiv,
                       input logic [31:0] epc, input logic [31:0] einst);
        vec_t v;
        v = '{r, rqr, rsv, rsd, idr, rdv, tgt, h, erv, eaddr, eiv, epc, einst};
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
        id_ready_i = 1'b0; redirect_valid_i = 1'b0; redirect_target_i = '0; halt_i = 1'b0;
    endtask

    // Transaction-level model state for the random phase
    logic [31:0] arch_pc;
    logic        m_out;
    logic        m_stale;
    logic        m_pres;
    logic [31:0] m_addr;
    logic [31:0] m_inst;
    int          m_cnt;
    logic        e_rv;
    logic        e_iv;

    initial begin
        idle_inputs();
        rst = 1'b1;

        //   rst rqr rsv rsdata        idr rdv tgt           h   erv eaddr         eiv epc           einst
        row(1, 0, 0, 32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         32'h0);
        row(0, 1, 0, 32'h0,         0, 0, 32'h0,         0,  1, 32'h8000_0000, 0, 32'h8000_0000, 32'h0);
        row(0, 0, 1, 32'h0000_0413, 0, 0, 32'h0,         0,  0, 32'h8000_0000, 0, 32'h8000_0000, 32'h0);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0,  0, 32'h8000_0000, 1, 32'h8000_0000, 32'h0000_0413);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0,  0, 32'h8000_0000, 1, 32'h8000_0000, 32'h0000_0413);
        row(0, 0, 0, 32'h0,         1, 0, 32'h0,         0,  0, 32'h8000_0000, 1, 32'h8000_0000, 32'h0000_0413);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0,  1, 32'h8000_0004, 0, 32'h8000_0004, 32'h0000_0413);
        row(0, 1, 0, 32'h0,         0, 0, 32'h0,         1,  0, 32'h8000_0004, 0, 32'h8000_0004, 32'h0000_0413);
        row(0, 1, 0, 32'h0,         0, 0, 32'h0,         0,  1, 32'h8000_0004, 0, 32'h8000_0004, 32'h0000_0413);
        row(0, 0, 0, 32'h0,         0, 1, 32'h8000_0103, 0,  0, 32'h8000_0004, 0, 32'h8000_0004, 32'h0000_0413);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0,  0, 32'h8000_0100, 0, 32'h8000_0100, 32'h0000_0413);
        row(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,         0,  0, 32'h8000_0100, 0, 32'h8000_0100, 32'h0000_0413);
        row(0, 1, 0, 32'h0,         0, 0, 32'h0,         0,  1, 32'h8000_0100, 0, 32'h8000_0100, 32'h0000_0413);
        row(0, 0, 1, 32'h1111_1111, 0, 0, 32'h0,         0,  0, 32'h8000_0100, 0, 32'h8000_0100, 32'h0000_0413);
        row(0, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0,  0, 32'h8000_0100, 0, 32'h8000_0100, 32'h1111_1111);
        row(0, 1, 0, 32'h0,         0, 0, 32'h0,         0,  1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h1111_1111);
        row(0, 0, 1, 32'h2222_2222, 0, 0, 32'h0,         0,  0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h1111_1111);
        row(0, 0, 0, 32'h0,         1, 0, 32'h0,         0,  0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h2222_2222);
        row(0, 1, 0, 32'h0,         0, 0, 32'h0,         0,  1, 32'h0000_0000, 0, 32'h0000_0000, 32'h2222_2222);
        row(0, 0, 1, 32'h3333_3333, 0, 1, 32'h8000_0200, 0,  0, 32'h0000_0000, 0, 32'h0000_0000, 32'h2222_2222);
        row(0, 0, 1, 32'h4444_4444, 0, 0, 32'h0,         0,  1, 32'h8000_0200, 0, 32'h8000_0200, 32'h2222_2222);
        row(1, 1, 0, 32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         32'h0);
        row(0, 0, 0, 32'h0,         0, 0, 32'h0,         0,  1, 32'h8000_0000, 0, 32'h8000_0000, 32'h0);
        row(0, 1, 0, 32'h0,         0, 1, 32'h0000_1000, 0,  0, 32'h8000_0000, 0, 32'h8000_0000, 32'h0);
        row(0, 1, 0, 32'h0,         0, 0, 32'h0,         0,  1, 32'h0000_1000, 0, 32'h0000_1000, 32'h0);

        // Directed table: drive on negedge, sample 1ns later, state advances on posedge.
        foreach (tbl[i]) begin
            @(negedge clk);
            rst               = tbl[i].rst;
            imem_req_ready_i  = tbl[i].rq_rdy;
            imem_rsp_valid_i  = tbl[i].rs_vld;
            imem_rsp_data_i   = tbl[i].rs_data;
            id_ready_i        = tbl[i].id_rdy;
            redirect_valid_i  = tbl[i].rd_vld;
            redirect_target_i = tbl[i].rd_tgt;
            halt_i            = tbl[i].hlt;
            #1;
            chk($sformatf("tbl[%0d].req_valid", i), {31'b0, imem_req_valid_o}, {31'b0, tbl[i].e_rv});
            chk($sformatf("tbl[%0d].req_addr", i),  imem_req_addr_o,            tbl[i].e_addr);
            chk($sformatf("tbl[%0d].id_valid", i),  {31'b0, id_valid_o},       {31'b0, tbl[i].e_iv});
            chk($sformatf("tbl[%0d].id_pc", i),     id_pc_o,                    tbl[i].e_pc);
            chk($sformatf("tbl[%0d].id_inst", i),   id_inst_o,                  tbl[i].e_inst);
        end

        // Random phase: fresh reset, then model-checked traffic with a variable-latency memory.
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        arch_pc = 32'h8000_0000;
        m_out = 1'b0; m_stale = 1'b0; m_pres = 1'b0; m_addr = '0; m_inst = '0; m_cnt = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc != 0) @(negedge clk);
            imem_req_ready_i  = ($urandom % 10) < 7;
            halt_i            = ($urandom % 10) == 0;
            redirect_valid_i  = ($urandom % 12) == 0;
            redirect_target_i = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            id_ready_i        = ($urandom % 10) < 6;
            if (m_out && m_cnt == 0) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = mem_word(m_addr);
            end else if (!m_out && ($urandom % 8) == 0) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = $urandom;
            end else begin
                imem_rsp_valid_i = 1'b0;
                imem_rsp_data_i  = '0;
            end
            #1;
            e_rv = !m_out && !m_pres && !halt_i && !redirect_valid_i;
            e_iv = m_pres && !redirect_valid_i;
            chk($sformatf("rnd[%0d].req_valid", cyc), {31'b0, imem_req_valid_o}, {31'b0, e_rv});
            chk($sformatf("rnd[%0d].id_valid", cyc),  {31'b0, id_valid_o},       {31'b0, e_iv});
            if (e_rv) chk($sformatf("rnd[%0d].req_addr", cyc), imem_req_addr_o, arch_pc);
            if (e_iv) begin
                chk($sformatf("rnd[%0d].id_pc", cyc),   id_pc_o,   arch_pc);
                chk($sformatf("rnd[%0d].id_inst", cyc), id_inst_o, m_inst);
            end

            @(posedge clk);
            if (m_pres) begin
                if (redirect_valid_i) m_pres = 1'b0;
                else if (id_ready_i) begin
                    arch_pc = arch_pc + 32'd4;
                    m_pres  = 1'b0;
                end
            end else if (m_out) begin
                if (imem_rsp_valid_i) begin
                    m_out = 1'b0;
                    if (!m_stale && !redirect_valid_i) begin
                        m_pres = 1'b1;
                        m_inst = mem_word(m_addr);
                    end
                end else begin
                    if (redirect_valid_i) m_stale = 1'b1;
                    m_cnt--;
                end
            end else if (e_rv && imem_req_ready_i) begin
                m_out   = 1'b1;
                m_stale = 1'b0;
                m_addr  = arch_pc;
                m_cnt   = $urandom_range(0, 3);
            end
            if (redirect_valid_i) arch_pc = {redirect_target_i[31:2], 2'b00};
        end

        @(negedge clk);
        idle_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
